keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans the 4x4 PmodKYPD keypad wired to JA: drives col[3:0], samples row[3:0].
- Synchronises, ghost-filters and debounces the key matrix.
- Presents one decoded key plus press/release event pulses to chara_control as the player B input.
- Sits directly upstream of the character controller; replaces raw row-only decoding with a full column-scanned, debounced key stream.

Parameters:
- SCAN_DIV, 100000, clk cycles each column is driven (1 ms at 100 MHz); legal range >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required before the accepted key changes; legal range 1..15.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous, active-low reset
- row  input  4  keypad rows, active-low (pulled up), asynchronous to clk
- col  output 4  keypad column drive, active-low, exactly one bit low at all times
- key_code  output 4  hex code of accepted key; valid only while key_valid=1
- key_valid  output 1  high while an accepted key is held
- key_press  output 1  one-cycle pulse when a key becomes accepted
- key_release  output 1  one-cycle pulse when the accepted key is dropped

Behaviour:
- Reset (rst=0, async): col=4'b1110, key_code=0, key_valid=0, key_press=0, key_release=0. All counters, sync flops, scan accumulators and debounce state are cleared; candidate and accepted are "none". Release of reset starts a fresh scan at column 0.
- Row sync: row passes through a 2-flop synchroniser; only the synchronised value is used.
- Scan FSM, states COL0..COL3, one per column:
  - In COLn, col has bit n low and the others high.
  - A dwell counter runs 0..SCAN_DIV-1.
  - On the cycle the dwell counter reaches SCAN_DIV-1, the synced rows are sampled into the scan accumulator. The counter then wraps to 0 and the FSM advances COLn -> COL(n+1); COL3 wraps to COL0.
- Scan evaluation, on the cycle after the COL3 sample:
  - Count the pressed positions (row bit low) across the 4 samples.
  - Exactly 1 pressed: candidate = that key's code.
  - 0 pressed, or 2 or more pressed (ghost/multi-key): candidate = none.
  - The accumulator is cleared for the next scan.
- Key map (row r, column c -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Debounce, applied at each evaluation:
  - candidate == previous candidate: stable_cnt increments, saturating at 15.
  - candidate differs: previous = candidate, stable_cnt = 1.
  - The accepted key is updated when stable_cnt >= DEBOUNCE_SCANS and candidate != accepted.
- Event outputs, registered, asserted on the cycle after evaluation:
  - none -> K: key_press=1, key_code=K, key_valid=1.
  - K -> none: key_release=1, key_valid=0; key_code holds K.
  - K1 -> K2, direct change: key_release=1 and key_press=1 in the same cycle; key_code=K2, key_valid stays 1.
  - Pulses are exactly one cycle wide; at most one event per full scan.
- Latency: a clean press lasting the whole scan is accepted after DEBOUNCE_SCANS evaluations. Worst case from press to key_press: (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 4 cycles.
- Held key: key_valid stays 1 with no further pulses.
- Bounce shorter than one scan never produces an event.
- Reset mid-scan or mid-debounce: all state is discarded; no pulse is emitted on reset release.

Test Plan:
Params for all scenarios: SCAN_DIV=8, DEBOUNCE_SCANS=3.
- Reset: hold rst=0 -> col=1110 and all key outputs 0. Release rst -> col steps 1110,1101,1011,0111, each held 8 cycles, repeating.
- Single press: pull row1 low only while col=1011 (key "6"), held continuously -> after the 3rd evaluation, key_press is a 1-cycle pulse with key_code=6 and key_valid=1. Release -> 3 scans later, key_release pulse and key_valid=0.
- Bounce: toggle key "A" (r0,c3) pressed/released on alternate scans for 10 scans -> no key_press or key_release, key_valid stays 0.
- Ghost: hold "1" (r0,c0) and "5" (r1,c1) together -> candidate none, no key_press. Releasing "5" only -> key_press with key_code=1 after 3 scans.
- Direct change: held "D" (r3,c3) accepted, then switch to "0" (r3,c0) within one scan -> after 3 scans, one cycle with key_press=1, key_release=1, key_code=0, key_valid=1.
- Reset mid-debounce: press "9", assert rst after 2 scans, release rst with the key still held -> key_press occurs only 3 full scans after reset release; no pulse at reset release.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key stream handed to the character controller.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;
    logic       key_release;

    // Scanner side: samples rows, drives columns and the key stream.
    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_press,
        output key_release
    );

    // Keypad / consumer side.
    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_press,
        input  key_release
    );
endinterface

// File: rtl/keypad_scanner.sv
// Column-scanned 4x4 keypad decoder: row synchroniser, per-scan single-key
// (ghost-rejecting) candidate, scan-count debounce and press/release pulses.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);

    localparam int unsigned DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_TH    = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_e;

    scan_state_e   state_q;
    logic [DW-1:0] dwell_q;
    logic [3:0]    col_q;
    logic [3:0]    row_meta_q, row_sync_q;
    logic [15:0]   acc_q, acc_d;
    logic          eval_q, eval_d;
    logic          prev_v_q, prev_v_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_press_q, key_press_d;
    logic          key_release_q, key_release_d;

    logic          sample_c;
    logic [4:0]    hits_c;
    logic [3:0]    pos_c;
    logic          cand_v_c;
    logic [3:0]    cand_code_c;

    // Matrix position {row, col} to printed key legend.
    function automatic logic [3:0] key_map(input logic [3:0] pos);
        case (pos)
            4'd0:    key_map = 4'h1;
            4'd1:    key_map = 4'h2;
            4'd2:    key_map = 4'h3;
            4'd3:    key_map = 4'hA;
            4'd4:    key_map = 4'h4;
            4'd5:    key_map = 4'h5;
            4'd6:    key_map = 4'h6;
            4'd7:    key_map = 4'hB;
            4'd8:    key_map = 4'h7;
            4'd9:    key_map = 4'h8;
            4'd10:   key_map = 4'h9;
            4'd11:   key_map = 4'hC;
            4'd12:   key_map = 4'h0;
            4'd13:   key_map = 4'hF;
            4'd14:   key_map = 4'hE;
            default: key_map = 4'hD;
        endcase
    endfunction

    assign sample_c = (dwell_q == DWELL_MAX);

    // Two-flop synchroniser; idle rows are pulled high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp.row;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan FSM: dwell on each column, then step to the next, driving col.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COL0;
            dwell_q <= '0;
            col_q   <= 4'b1110;
        end else if (sample_c) begin
            dwell_q <= '0;
            case (state_q)
                COL0:    begin state_q <= COL1; col_q <= 4'b1101; end
                COL1:    begin state_q <= COL2; col_q <= 4'b1011; end
                COL2:    begin state_q <= COL3; col_q <= 4'b0111; end
                default: begin state_q <= COL0; col_q <= 4'b1110; end
            endcase
        end else begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    // Accumulate pressed positions over one scan; cleared once evaluated.
    always_comb begin
        acc_d  = acc_q;
        eval_d = sample_c && (state_q == COL3);
        if (eval_q) begin
            acc_d = '0;
        end
        if (sample_c) begin
            for (int r = 0; r < 4; r++) begin
                acc_d[{2'(r), 2'(state_q)}] = ~row_sync_q[r];
            end
        end
    end

    // Candidate is valid only when exactly one position was seen pressed.
    always_comb begin
        hits_c = '0;
        pos_c  = '0;
        for (int i = 0; i < 16; i++) begin
            if (acc_q[i]) begin
                hits_c = hits_c + 5'd1;
                pos_c  = 4'(i);
            end
        end
        cand_v_c    = (hits_c == 5'd1);
        cand_code_c = key_map(pos_c);
    end

    // Debounce and event generation, applied once per completed scan.
    always_comb begin
        prev_v_d      = prev_v_q;
        prev_code_d   = prev_code_q;
        stable_d      = stable_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        if (eval_q) begin
            if ((cand_v_c == prev_v_q) && (!cand_v_c || (cand_code_c == prev_code_q))) begin
                stable_d = (stable_q == 4'hF) ? stable_q : stable_q + 4'd1;
            end else begin
                prev_v_d    = cand_v_c;
                prev_code_d = cand_code_c;
                stable_d    = 4'd1;
            end
            if ((stable_d >= DEB_TH) &&
                ((cand_v_c != key_valid_q) || (cand_v_c && (cand_code_c != key_code_q)))) begin
                key_valid_d   = cand_v_c;
                key_release_d = key_valid_q;
                if (cand_v_c) begin
                    key_code_d  = cand_code_c;
                    key_press_d = 1'b1;
                end
            end
        end
    end

    // Scan accumulator, debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q         <= '0;
            eval_q        <= 1'b0;
            prev_v_q      <= 1'b0;
            prev_code_q   <= '0;
            stable_q      <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            eval_q        <= eval_d;
            prev_v_q      <= prev_v_d;
            prev_code_q   <= prev_code_d;
            stable_q      <= stable_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign kp.col         = col_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_press   = key_press_q;
    assign kp.key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: an ideal keypad matrix driven per scan, a per-scan
// behavioural debounce model pushing expected events, and a monitor popping them.
module tb_keypad_scanner;

    localparam int SD   = 8;
    localparam int DEB  = 3;
    localparam int SCAN = 4 * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.master)
    );

    logic [15:0] keys = '0;
    logic [3:0]  row_drv;

    // Ideal matrix: a row reads low when a pressed key sits on the driven column.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp_if.col[c]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kp_if.row = row_drv;

    // Clock edges since reset release.
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int       cyc;
        bit       press;
        bit       rel;
        logic [3:0] code;
        bit       valid;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    int  hist[$];
    int  acc_k;
    int  last_code;
    int  scan_idx;
    int  legend [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp_v, cyc, $time);
        end
    endtask

    // Monitor: reset values, column walk, and every pulse against the queue.
    always @(negedge clk) begin
        logic [3:0] one;
        logic [3:0] exp_col;
        ev_t e;
        one = 4'b0001;
        if (!rst) begin
            chk("rst_col", int'(kp_if.col), 14);
            chk("rst_valid", int'(kp_if.key_valid), 0);
            chk("rst_press", int'(kp_if.key_press), 0);
            chk("rst_release", int'(kp_if.key_release), 0);
            chk("rst_code", int'(kp_if.key_code), 0);
        end else begin
            exp_col = ~(one << ((cyc / SD) % 4));
            chk("col", int'(kp_if.col), int'(exp_col));
            if (kp_if.key_press || kp_if.key_release) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", int'({kp_if.key_press, kp_if.key_release}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_press", int'(kp_if.key_press), int'(e.press));
                    chk("ev_release", int'(kp_if.key_release), int'(e.rel));
                    chk("ev_code", int'(kp_if.key_code), int'(e.code));
                    chk("ev_valid", int'(kp_if.key_valid), int'(e.valid));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missing_event_at", cyc, e.cyc);
            end
        end
    end

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        acc_k     = -1;
        last_code = 0;
        scan_idx  = 0;
    endtask

    // Apply one matrix state for a whole scan and predict its outcome.
    task automatic run_scan(input logic [15:0] m);
        int tgt, n, cand, same;
        ev_t e;
        tgt = scan_idx * SCAN + 2;
        n = 0;
        while (cyc < tgt && n < 4 * SCAN) begin
            @(negedge clk);
            n++;
        end
        if (cyc != tgt) chk("scan_align", cyc, tgt);
        #1;
        chk("lvl_valid", int'(kp_if.key_valid), (acc_k >= 0) ? 1 : 0);
        chk("lvl_code", int'(kp_if.key_code), last_code);
        keys = m;
        cand = ($countones(m) == 1) ? legend[$clog2(m)] : -1;
        hist.push_back(cand);
        if (hist.size() > DEB) void'(hist.pop_front());
        same = (hist.size() == DEB) ? 1 : 0;
        foreach (hist[i]) if (hist[i] != cand) same = 0;
        if (same == 1 && cand != acc_k) begin
            e.cyc   = scan_idx * SCAN + SCAN + 1;
            e.press = (cand >= 0);
            e.rel   = (acc_k >= 0);
            e.code  = 4'((cand >= 0) ? cand : last_code);
            e.valid = (cand >= 0);
            exp_q.push_back(e);
            if (cand >= 0) last_code = cand;
            acc_k = cand;
        end
        scan_idx++;
    endtask

    task automatic scans(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_scan(m);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (n) @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m;
        logic [15:0] cur;
        int r, a, b;
        model_reset();
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        model_reset();

        scans(16'h0000, 2);
        // Key 6: row1, col2.
        scans(16'h0040, 5);
        scans(16'h0000, 5);
        // Bounce on A (row0, col3) every other scan.
        for (int i = 0; i < 5; i++) begin
            run_scan(16'h0008);
            run_scan(16'h0000);
        end
        scans(16'h0000, 2);
        // Ghost: 1 and 5 together, then 1 alone.
        scans(16'h0021, 5);
        scans(16'h0001, 5);
        scans(16'h0000, 4);
        // Direct change D -> 0.
        scans(16'h8000, 5);
        scans(16'h1000, 5);
        scans(16'h0000, 4);
        // Reset mid-debounce on 9 (row2, col2), key held through reset.
        scans(16'h0400, 3);
        while (cyc < 2 * SCAN + 12) @(negedge clk);
        do_reset(4);
        scans(16'h0400, 5);
        scans(16'h0000, 4);

        // Randomised matrix sequences.
        cur = '0;
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            m = cur;
            if (r >= 5 && r <= 6) m = '0;
            else if (r >= 7 && r <= 8) m = 16'(1) << a;
            else if (r == 9) m = (16'(1) << a) | (16'(1) << b);
            cur = m;
            run_scan(m);
        end
        scans(16'h0000, 5);
        repeat (SCAN) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
